// File: rtl/alu_div_pkg.sv
// rtl/alu_div_pkg.sv - shared width, counter size and FSM state type for the sequential divider
package alu_div_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step (shift, trial subtract, select)
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           carry;
  logic           fits;

  assign shifted = {rem_in, quo_in[WIDTH-1]};

  // rem - divisor as rem + ~divisor + 1; carry out set means no borrow
  assign {carry, diff} = {1'b0, shifted} + {1'b0, ~{1'b0, divisor}} + {{(WIDTH + 1){1'b0}}, 1'b1};

  // an accepted trial must leave a remainder that fits back into WIDTH bits
  assign fits    = carry & ~diff[WIDTH];
  assign rem_out = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_out = {quo_in[WIDTH-2:0], fits};

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle signed/unsigned restoring divider, one quotient bit per clock
// Optional SEQ_DIV_ZERO_TRAP_EN: divide-by-zero skips RUN, returns Q=0/R=dividend and flags oDivZero.
module seq_divider
  import alu_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic             iSigned,
  input  logic [WIDTH-1:0] iX,
  input  logic [WIDTH-1:0] iY,
  output logic             oBusy,
  output logic             oValid,
`ifdef SEQ_DIV_ZERO_TRAP_EN
  output logic             oDivZero,
`endif
  output logic [WIDTH-1:0] oQ,
  output logic [WIDTH-1:0] oR
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dvsr;
  logic [WIDTH-1:0] rem_nx, quo_nx;
  logic             sign_q, sign_r;
  logic             neg_x, neg_y;

  assign neg_x = iSigned & iX[WIDTH-1];
  assign neg_y = iSigned & iY[WIDTH-1];

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .quo_in  (quo),
    .divisor (dvsr),
    .rem_out (rem_nx),
    .quo_out (quo_nx)
  );

`ifdef SEQ_DIV_ZERO_TRAP_EN
  logic dz;
  assign oDivZero = (state == DONE) & dz;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (iStart) begin
`ifdef SEQ_DIV_ZERO_TRAP_EN
          state_nx = (iY == '0) ? FIXUP : RUN;
`else
          state_nx = RUN;
`endif
        end
      end
      RUN:     if (cnt == CW'(WIDTH - 1)) state_nx = FIXUP;
      FIXUP:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state  <= IDLE;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      oQ     <= '0;
      oR     <= '0;
`ifdef SEQ_DIV_ZERO_TRAP_EN
      dz     <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (iStart) begin
            cnt    <= '0;
            rem    <= '0;
            quo    <= neg_x ? -iX : iX;
            dvsr   <= neg_y ? -iY : iY;
            // a zero divisor keeps the all-ones quotient un-negated
            sign_q <= (neg_x ^ neg_y) & (|iY);
            sign_r <= neg_x;
`ifdef SEQ_DIV_ZERO_TRAP_EN
            dz     <= (iY == '0);
`endif
          end
        end
        RUN: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + 1'b1;
        end
        FIXUP: begin
`ifdef SEQ_DIV_ZERO_TRAP_EN
          if (dz) begin
            // quo still holds |dividend| because RUN was skipped
            oQ <= '0;
            oR <= sign_r ? -quo : quo;
          end else begin
            oQ <= sign_q ? -quo : quo;
            oR <= sign_r ? -rem : rem;
          end
`else
          oQ <= sign_q ? -quo : quo;
          oR <= sign_r ? -rem : rem;
`endif
        end
        default: ;
      endcase
    end
  end

  assign oBusy  = (state != IDLE);
  assign oValid = (state == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench: directed and random divides against an arithmetic reference
module tb_seq_divider;

  localparam int W = 32;

  logic         iClk = 1'b0;
  logic         iRst;
  logic         iStart;
  logic         iSigned;
  logic [W-1:0] iX, iY;
  logic         oBusy, oValid;
  logic [W-1:0] oQ, oR;
`ifdef SEQ_DIV_ZERO_TRAP_EN
  logic         oDivZero;
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  seq_divider dut (
    .iClk     (iClk),
    .iRst     (iRst),
    .iStart   (iStart),
    .iSigned  (iSigned),
    .iX       (iX),
    .iY       (iY),
    .oBusy    (oBusy),
    .oValid   (oValid),
`ifdef SEQ_DIV_ZERO_TRAP_EN
    .oDivZero (oDivZero),
`endif
    .oQ       (oQ),
    .oR       (oR)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always @(posedge iClk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference: plain integer division; latency counted from the drive cycle
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input bit s, input int now);
    exp_t   e;
    longint sx, sy;
    e.dz  = 1'b0;
    e.due = now + W + 2;
    if (y == 0) begin
      e.r = x;
      if (TRAP) begin
        e.q   = '0;
        e.dz  = 1'b1;
        e.due = now + 2;
      end else begin
        e.q = '1;
      end
    end else if (s) begin
      sx  = longint'($signed(x));
      sy  = longint'($signed(y));
      e.q = W'(sx / sy);
      e.r = W'(sx % sy);
    end else begin
      e.q = x / y;
      e.r = x % y;
    end
    return e;
  endfunction

  always @(negedge iClk) begin
    if (!iRst && oValid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got oValid=1 expected no result pending (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", oQ, e.q);
        check("remainder", oR, e.r);
        check("valid_cycle", W'(cyc), W'(e.due));
`ifdef SEQ_DIV_ZERO_TRAP_EN
        check("divzero_flag", W'(oDivZero), W'(e.dz));
`endif
      end
    end
  end

  // called at a negedge; returns at the negedge after the sampling edge
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input bit s, input bit accept);
    iX      = x;
    iY      = y;
    iSigned = s;
    iStart  = 1'b1;
    if (accept) sb.push_back(model(x, y, s, cyc));
    @(negedge iClk);
    iStart = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((oBusy || sb.size() != 0) && n < 200) begin
      @(negedge iClk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got busy after %0d cycles expected idle", n);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bcnt;
    logic [W-1:0] x, y;
    bit s;
    iRst = 1'b1; iStart = 1'b0; iSigned = 1'b0; iX = '0; iY = '0;
    repeat (2) @(negedge iClk);
    check("reset_busy", W'(oBusy), 0);
    check("reset_valid", W'(oValid), 0);
    check("reset_q", oQ, 0);
    check("reset_r", oR, 0);
    iRst = 1'b0;
    @(negedge iClk);

    issue(100, 7, 0, 1);
    bcnt = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge iClk);
      if (oBusy) bcnt++;
      else break;
    end
    check("busy_cycles", W'(bcnt), W + 2);
    @(negedge iClk);
    check("hold_q", oQ, 14);
    check("hold_r", oR, 2);

    issue(32'hFFFF_FFF9, 32'h2, 1, 1);         wait_idle();
    issue(32'h7, 32'hFFFF_FFFE, 1, 1);         wait_idle();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1, 1); wait_idle();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 0, 1); wait_idle();
    issue(32'h1234, 0, 0, 1);                  wait_idle();
    issue(32'h1234, 0, 1, 1);                  wait_idle();
    issue(32'hFFFF_0000, 0, 1, 1);             wait_idle();

    issue(50, 5, 0, 1);
    repeat (8) @(negedge iClk);
    issue(9, 3, 0, 0);
    wait_idle();
    issue(9, 3, 0, 1);
    wait_idle();

    issue(100, 3, 0, 1);
    repeat (14) @(negedge iClk);
    iRst = 1'b1;
    #1;
    check("abort_busy", W'(oBusy), 0);
    check("abort_valid", W'(oValid), 0);
    check("abort_q", oQ, 0);
    check("abort_r", oR, 0);
    sb.delete();
    @(negedge iClk);
    iRst = 1'b0;
    repeat (40) @(negedge iClk);
    issue(20, 6, 0, 1);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      x = $urandom;
      y = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 6))
        0: y = W'($urandom_range(1, 15));
        1: y = '0;
        2: y = '1;
        3: x = 32'h8000_0000;
        4: y = y >> $urandom_range(1, 31);
        default: ;
      endcase
      issue(x, y, s, 1);
      // leave some ops back-to-back, others separated by idle cycles
      if (i % 3 == 0) wait_idle();
      else begin
        for (int k = 0; k < 200 && oBusy; k++) @(negedge iClk);
      end
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
